// File: rtl/rgb_axis_packer_if.sv
// Pixel-in / stream-out bus of rgb_axis_packer, plus the pixel flag type.
//   r, g, b, flags_in, in_valid / in_ready          : pixel handshake (upstream)
//   out_tdata, out_tvalid, out_tready, out_tuser,
//   out_tlast                                       : AXI4-Stream word (downstream)
// Modport master is the packer's view: it receives pixels and drives the stream.
// Modport slave is the environment's view: it drives pixels and sinks the stream.

package rgb_axis_packer_pkg;
    typedef struct packed {
        logic sof;   // first pixel of frame
        logic eol;   // last pixel of line
    } flags_t;
endpackage

interface rgb_axis_packer_if;
    import rgb_axis_packer_pkg::*;

    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    flags_t      flags_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tuser;
    logic        out_tlast;

    modport master (
        input  r, g, b, flags_in, in_valid, out_tready,
        output in_ready, out_tdata, out_tvalid, out_tuser, out_tlast
    );

    modport slave (
        output r, g, b, flags_in, in_valid, out_tready,
        input  in_ready, out_tdata, out_tvalid, out_tuser, out_tlast
    );
endinterface

// File: rtl/rgb_axis_packer.sv
// rgb_axis_packer: packs 24-bit RGB pixels into 32-bit stream words, four
// pixels per three words, little-endian byte order (first pixel's blue in
// byte 0). A line end flushes the partial group padded with PAD_BYTE.
// Words pass through a small FIFO so downstream stalls do not reach
// upstream combinationally.
//   clk, resetn   : clock, synchronous active-low reset
//   bus (master)  : pixel handshake in, AXI4-Stream word out (see _if file)
//   err_misalign  : sticky, sof arrived while a partial group was pending
// Parameters: PAD_BYTE fill byte, FIFO_DEPTH word FIFO depth (power of 2, >= 4).

module rgb_axis_packer
    import rgb_axis_packer_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    rgb_axis_packer_if.master   bus,
    output logic                err_misalign
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t        phase, phase_nxt, eph;
    logic [23:0]   res, res_nxt;
    logic          sof_pend, sof_pend_nxt;
    logic          err_nxt;
    logic          accept, tu;
    logic [23:0]   pix;
    entry_t        w0, w1;
    logic          push0, push1;
    logic [1:0]    n_push;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;
    logic [CW-1:0] count, count_nxt;
    logic          pop;
    logic          in_ready_q;
    entry_t        head;

    // ---------------------------------------------------------------
    // Phase FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) phase <= PH0;
        else         phase <= phase_nxt;
    end

    // ---------------------------------------------------------------
    // Phase FSM: next state and word assembly
    // ---------------------------------------------------------------
    always_comb begin
        phase_nxt    = phase;
        res_nxt      = res;
        sof_pend_nxt = sof_pend;
        err_nxt      = err_misalign;
        push0        = 1'b0;
        push1        = 1'b0;
        w0           = '0;
        w1           = '0;
        eph          = phase;
        tu           = 1'b0;
        accept       = bus.in_valid && in_ready_q;
        pix          = {bus.r, bus.g, bus.b};

        if (accept) begin
            // A sof restarts the group: any residual bytes are dropped.
            eph = bus.flags_in.sof ? PH0 : phase;
            if (bus.flags_in.sof && phase != PH0) err_nxt = 1'b1;
            tu = sof_pend || bus.flags_in.sof;

            case (eph)
                PH0: begin
                    res_nxt   = pix;
                    phase_nxt = PH1;
                    if (bus.flags_in.eol) begin
                        push0   = 1'b1;
                        w0.data = {PAD_BYTE, pix};
                    end
                end
                PH1: begin
                    push0     = 1'b1;
                    w0.data   = {pix[7:0], res};
                    res_nxt   = {8'h00, pix[23:8]};
                    phase_nxt = PH2;
                    if (bus.flags_in.eol) begin
                        push1   = 1'b1;
                        w1.data = {PAD_BYTE, PAD_BYTE, pix[23:8]};
                    end
                end
                PH2: begin
                    push0     = 1'b1;
                    w0.data   = {pix[15:0], res[15:0]};
                    res_nxt   = {16'h0000, pix[23:16]};
                    phase_nxt = PH3;
                    if (bus.flags_in.eol) begin
                        push1   = 1'b1;
                        w1.data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, pix[23:16]};
                    end
                end
                PH3: begin
                    push0     = 1'b1;
                    w0.data   = {pix, res[7:0]};
                    phase_nxt = PH0;
                end
            endcase

            if (bus.flags_in.eol) phase_nxt = PH0;

            // tuser goes on the first word pushed after sof; tlast on the last.
            w0.tuser = tu;
            w0.tlast = bus.flags_in.eol && !push1;
            w1.tlast = bus.flags_in.eol;
            sof_pend_nxt = push0 ? 1'b0 : tu;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO: up to two pushes and one pop per cycle
    // ---------------------------------------------------------------
    always_comb begin
        n_push    = {1'b0, push0} + {1'b0, push1};
        pop       = (count != '0) && bus.out_tready;
        count_nxt = count + CW'(n_push) - CW'(pop);
        wr_ptr1   = wr_ptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (resetn && push0) mem[wr_ptr]  <= w0;
        if (resetn && push1) mem[wr_ptr1] <= w1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            res          <= '0;
            sof_pend     <= 1'b0;
            err_misalign <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            res          <= res_nxt;
            sof_pend     <= sof_pend_nxt;
            err_misalign <= err_nxt;
            wr_ptr       <= wr_ptr + AW'(n_push);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count        <= count_nxt;
            // Ready only while two free slots remain after this edge, so an
            // eol flush can always push both words next cycle.
            in_ready_q   <= (count_nxt <= READY_MAX);
        end
    end

    // Head is forced to zero when empty so the bus is clean after reset.
    assign head           = mem[rd_ptr];
    assign bus.in_ready   = in_ready_q;
    assign bus.out_tvalid = (count != '0);
    assign bus.out_tdata  = bus.out_tvalid ? head.data  : 32'h0;
    assign bus.out_tuser  = bus.out_tvalid ? head.tuser : 1'b0;
    assign bus.out_tlast  = bus.out_tvalid ? head.tlast : 1'b0;

endmodule
